// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined RV32I ALU:
//   - op-code width and op-code localparams
//   - packed flag bundle carried from the datapath into the output stage
//   - is_legal_op: classifies an op code as a member of the supported set
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b1001;

  // Result flags, in the order they are presented on the output ports.
  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '{
    zero:    1'b0,
    neg:     1'b0,
    carry:   1'b0,
    ovf:     1'b0,
    illegal: 1'b0
  };

  // Returns 1 when the op code belongs to the supported register-register set.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SLL,
      OP_SRL, OP_SUB, OP_SRA, OP_SLT, OP_SLTU: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational XLEN-wide integer datapath.
//
// Ports:
//   a_i      [XLEN-1:0]  operand A
//   b_i      [XLEN-1:0]  operand B (low SHAMT_W bits are the shift amount)
//   op_i     [OP_W-1:0]  op code
//   result_o [XLEN-1:0]  result (0 for an unknown op code)
//   flags_o  alu_flags_t zero / neg / carry / ovf / illegal
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [OP_W-1:0] op_i,
  output logic [XLEN-1:0] result_o,
  output alu_flags_t      flags_o
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt_s;
  logic               is_sub_s;
  logic [XLEN-1:0]    b_eff_s;
  logic [XLEN:0]      sum_s;
  logic               arith_ovf_s;
  logic               slt_s;
  logic               sltu_s;
  logic [XLEN-1:0]    sra_s;
  logic [XLEN-1:0]    result_s;
  alu_flags_t         flags_s;

  // Upper bits of B are deliberately ignored for shifts.
  assign shamt_s  = b_i[SHAMT_W-1:0];

  // ADD and SUB share one XLEN+1 adder: SUB is A + ~B + 1, so the carry-out
  // doubles as the not-borrow indication.
  assign is_sub_s = (op_i == OP_SUB);
  assign b_eff_s  = is_sub_s ? ~b_i : b_i;
  assign sum_s    = {1'b0, a_i} + {1'b0, b_eff_s} + {{XLEN{1'b0}}, is_sub_s};

  // Signed overflow: both adder inputs share a sign that the sum does not.
  assign arith_ovf_s = (a_i[XLEN-1] == b_eff_s[XLEN-1]) &&
                       (sum_s[XLEN-1] != a_i[XLEN-1]);

  assign slt_s  = ($signed(a_i) < $signed(b_i));
  assign sltu_s = (a_i < b_i);
  assign sra_s  = $signed(a_i) >>> shamt_s;

  // Op decode: select the result and the adder-only flags.
  always_comb begin
    result_s        = {XLEN{1'b0}};
    flags_s         = FLAGS_CLEAR;
    flags_s.illegal = !is_legal_op(op_i);
    case (op_i)
      OP_AND:  result_s = a_i & b_i;
      OP_OR:   result_s = a_i | b_i;
      OP_XOR:  result_s = a_i ^ b_i;
      OP_ADD, OP_SUB: begin
        result_s      = sum_s[XLEN-1:0];
        flags_s.carry = sum_s[XLEN];
        flags_s.ovf   = arith_ovf_s;
      end
      OP_SLL:  result_s = a_i << shamt_s;
      OP_SRL:  result_s = a_i >> shamt_s;
      OP_SRA:  result_s = sra_s;
      OP_SLT:  result_s = {{(XLEN-1){1'b0}}, slt_s};
      OP_SLTU: result_s = {{(XLEN-1){1'b0}}, sltu_s};
      default: result_s = {XLEN{1'b0}};
    endcase
    // zero/neg always reflect the final result, including the illegal case.
    flags_s.zero = (result_s == {XLEN{1'b0}});
    flags_s.neg  = result_s[XLEN-1];
  end

  assign result_o = result_s;
  assign flags_o  = flags_s;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined integer ALU with valid/ready handshake on both sides.
// Stage 1 captures operands, op and tag; alu_core evaluates between the
// stages; stage 2 captures result and flags and drives every out_* port
// straight from flops. Holds up to two ops under backpressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   in_a, in_b [XLEN]        operands
//   in_op [4]                op code
//   in_tag [TAG_W]           sideband tag carried with the op
//   out_valid / out_ready    downstream handshake
//   out_result [XLEN]        result
//   out_zero, out_neg,
//   out_carry, out_ovf       result flags
//   out_illegal              op code not supported
//   out_tag [TAG_W]          tag of the op
// -----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]  s1_a_q,     s1_a_d;
  logic [XLEN-1:0]  s1_b_q,     s1_b_d;
  logic [OP_W-1:0]  s1_op_q,    s1_op_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  // Stage 2 state (drives the outputs)
  logic             s2_valid_q,  s2_valid_d;
  logic [XLEN-1:0]  s2_result_q, s2_result_d;
  alu_flags_t       s2_flags_q,  s2_flags_d;
  logic [TAG_W-1:0] s2_tag_q,    s2_tag_d;

  // Handshake and datapath wiring
  logic             s2_adv_s;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic [XLEN-1:0]  core_result_s;
  alu_flags_t       core_flags_s;

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .op_i     (s1_op_q),
    .result_o (core_result_s),
    .flags_o  (core_flags_s)
  );

  // Handshake: stage 2 frees when empty or drained; stage 1 frees when empty
  // or moving into stage 2. in_ready therefore depends combinationally on
  // out_ready only.
  always_comb begin
    s2_adv_s   = !s2_valid_q || out_ready;
    in_ready_s = !s1_valid_q || s2_adv_s;
    in_xfer_s  = in_valid && in_ready_s;
  end

  // Stage 1 next state: capture on an input transfer, otherwise hold data.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (in_ready_s) begin
      // Whatever was in stage 1 has moved on; refill or go empty.
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (in_xfer_s) begin
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_op_d  = in_op;
      s1_tag_d = in_tag;
    end else begin
      s1_a_d   = s1_a_q;
      s1_b_d   = s1_b_q;
      s1_op_d  = s1_op_q;
      s1_tag_d = s1_tag_q;
    end
  end

  // Stage 2 next state: data only changes when a real op arrives, so held
  // outputs stay bit-stable during a stall.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    s2_tag_d    = s2_tag_q;
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s2_adv_s && s1_valid_q) begin
      s2_result_d = core_result_s;
      s2_flags_d  = core_flags_s;
      s2_tag_d    = s1_tag_q;
    end else begin
      s2_result_d = s2_result_q;
      s2_flags_d  = s2_flags_q;
      s2_tag_d    = s2_tag_q;
    end
  end

  // Pipeline registers; reset discards all in-flight ops and wins over any
  // simultaneous transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= {XLEN{1'b0}};
      s1_b_q      <= {XLEN{1'b0}};
      s1_op_q     <= OP_AND;
      s1_tag_q    <= {TAG_W{1'b0}};
      s2_valid_q  <= 1'b0;
      s2_result_q <= {XLEN{1'b0}};
      s2_flags_q  <= FLAGS_CLEAR;
      s2_tag_q    <= {TAG_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_zero    = s2_flags_q.zero;
  assign out_neg     = s2_flags_q.neg;
  assign out_carry   = s2_flags_q.carry;
  assign out_ovf     = s2_flags_q.ovf;
  assign out_illegal = s2_flags_q.illegal;
  assign out_tag     = s2_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Directed self-checking bench for alu_pipe (XLEN=32, TAG_W=5).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// Flags are compared as a 5-bit vector {zero, neg, carry, ovf, illegal}.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [3:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       flags_w;

  int n_checks = 0;
  int n_errors = 0;

  assign flags_w = {out_zero, out_neg, out_carry, out_ovf, out_illegal};

  always #5 clk = ~clk;

  alu_pipe #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_carry   (out_carry),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal),
    .out_tag     (out_tag)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Single op with out_ready=1: not visible at N+1, visible at N+2, gone at N+3.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input logic [4:0] exp_flags);
    drive(op, a, b, tag);
    tick();
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'hDEAD_BEEF;
    check({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_res"},   out_result, exp_res);
    check({name, "_flags"}, {27'd0, flags_w}, {27'd0, exp_flags});
    check({name, "_tag"},   {27'd0, out_tag}, {27'd0, tag});
    tick();
    check({name, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_op     = 4'd0;
    in_tag    = 5'd0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags",  {27'd0, flags_w}, 32'd0);
    check("rst_tag",    {27'd0, out_tag}, 32'd0);
    check("rst_ready",  {31'd0, in_ready}, 32'd1);

    // Arithmetic, logic, shift, compare, illegal
    run_op("add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3,  32'h8000_0000, 5'b01010);
    run_op("add_carry", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd11, 32'h0000_0000, 5'b10100);
    run_op("sra",       4'b0111, 32'hF000_0000, 32'h0000_0024, 5'd12, 32'hFF00_0000, 5'b01000);
    run_op("srl",       4'b0101, 32'hF000_0000, 32'h0000_0024, 5'd13, 32'h0F00_0000, 5'b00000);
    run_op("sll31",     4'b0100, 32'h0000_0001, 32'h0000_001F, 5'd14, 32'h8000_0000, 5'b01000);
    run_op("sll33",     4'b0100, 32'h0000_0001, 32'h0000_0021, 5'd15, 32'h0000_0002, 5'b00000);
    run_op("slt",       4'b1000, 32'h8000_0000, 32'h0000_0000, 5'd16, 32'h0000_0001, 5'b00000);
    run_op("sltu",      4'b1001, 32'h8000_0000, 32'h0000_0000, 5'd17, 32'h0000_0000, 5'b10000);
    run_op("illegal",   4'b1111, 32'h0000_0123, 32'h0000_0456, 5'd18, 32'h0000_0000, 5'b10001);
    run_op("and",       4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd19, 32'hF000_F000, 5'b01000);
    run_op("or",        4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 5'd20, 32'h0F0F_00F0, 5'b00000);
    run_op("xor",       4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd21, 32'h5A5A_A5A5, 5'b00000);

    // Back-to-back SUBs come out on consecutive cycles
    drive(4'b0110, 32'd5, 32'd5, 5'd1);
    tick();
    drive(4'b0110, 32'd0, 32'd1, 5'd2);
    tick();
    in_valid = 1'b0;
    check("sub0_valid", {31'd0, out_valid}, 32'd1);
    check("sub0_res",   out_result, 32'h0000_0000);
    check("sub0_flags", {27'd0, flags_w}, {27'd0, 5'b10100});
    check("sub0_tag",   {27'd0, out_tag}, 32'd1);
    tick();
    check("sub1_valid", {31'd0, out_valid}, 32'd1);
    check("sub1_res",   out_result, 32'hFFFF_FFFF);
    check("sub1_flags", {27'd0, flags_w}, {27'd0, 5'b01000});
    check("sub1_tag",   {27'd0, out_tag}, 32'd2);
    tick();
    check("sub_drain",  {31'd0, out_valid}, 32'd0);

    // Backpressure: two accepts, then in_ready drops and outputs hold
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd4);
    #1;
    check("bp_rdy0", {31'd0, in_ready}, 32'd1);
    tick();
    drive(4'b0010, 32'd2, 32'd2, 5'd5);
    #1;
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    drive(4'b0010, 32'd3, 32'd3, 5'd6);
    #1;
    check("bp_rdy2",    {31'd0, in_ready}, 32'd0);
    check("bp_hold_v0", {31'd0, out_valid}, 32'd1);
    check("bp_hold_r0", out_result, 32'd2);
    check("bp_hold_t0", {27'd0, out_tag}, 32'd4);
    tick();
    check("bp_rdy3",    {31'd0, in_ready}, 32'd0);
    check("bp_hold_r1", out_result, 32'd2);
    check("bp_hold_t1", {27'd0, out_tag}, 32'd4);
    check("bp_hold_f1", {27'd0, flags_w}, 32'd0);
    tick();
    check("bp_hold_r2", out_result, 32'd2);
    check("bp_hold_v2", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_rdy4", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_out2_r", out_result, 32'd4);
    check("bp_out2_t", {27'd0, out_tag}, 32'd5);
    drive(4'b0010, 32'd4, 32'd4, 5'd7);
    tick();
    in_valid = 1'b0;
    check("bp_out3_r", out_result, 32'd6);
    check("bp_out3_t", {27'd0, out_tag}, 32'd6);
    tick();
    check("bp_out4_r", out_result, 32'd8);
    check("bp_out4_t", {27'd0, out_tag}, 32'd7);
    check("bp_out4_v", {31'd0, out_valid}, 32'd1);
    tick();
    check("bp_drain",  {31'd0, out_valid}, 32'd0);

    // Reset with two ops in flight and a simultaneous input offer
    out_ready = 1'b0;
    drive(4'b0010, 32'd9, 32'd1, 5'd8);
    tick();
    drive(4'b0010, 32'd7, 32'd1, 5'd9);
    tick();
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    check("mid_res",   out_result, 32'd10);
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(4'b0010, 32'd5, 32'd5, 5'd10);
    tick();
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_res",   out_result, 32'd0);
    check("rst2_tag",   {27'd0, out_tag}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst2_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst2_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised two-stage pipelined integer ALU for the RV32I pipeline.
- Operand width is generic, and the full RV32I register-register op set is supported, including arithmetic shift and set-less-than.
- Flags (zero, negative, carry, overflow) are produced for every op.
- Operands and a tag travel through a valid/ready handshake with backpressure, so the block can sit between issue and writeback with stalls.

Parameters:
XLEN, 32, operand and result width (>= 8, power of two)
TAG_W, 5, width of sideband tag (e.g. rd index) carried with each op
SHAMT_W, $clog2(XLEN), derived; low bits of B used as shift amount

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream op present
in_ready  out  1  block accepts op this cycle
in_a  in  XLEN  operand A
in_b  in  XLEN  operand B
in_op  in  4  op code (see Behaviour)
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_result  out  XLEN  result
out_zero  out  1  result == 0
out_neg  out  1  result[XLEN-1]
out_carry  out  1  carry-out of ADD / not-borrow of SUB, else 0
out_ovf  out  1  signed overflow of ADD/SUB, else 0
out_illegal  out  1  op code not in table
out_tag  out  TAG_W  tag of the op

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports clk and rst.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, all flags 0, out_tag=0. in_ready=1 in the first cycle after reset.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0011 XOR.
  - 0101 SRL; 0100 SLL; 0111 SRA (sign-filling, shift = B[SHAMT_W-1:0]).
  - 1000 SLT signed, result {0..,1} or 0.
  - 1001 SLTU unsigned.
  - Any other code: result 0, out_illegal=1.
- Arithmetic: ADD/SUB computed in XLEN+1 bits.
  - carry = bit XLEN of the sum; SUB uses A + ~B + 1.
  - ovf = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is B (ADD) or ~B (SUB).
  - zero and neg are computed from the final result for every op (no stale flag).
- Pipeline:
  - Stage 1 registers the inputs plus the decoded op.
  - Stage 2 registers the result and flags, and drives the out_* ports directly from flops.
  - Latency: accept in cycle N gives out_valid in cycle N+2 when there is no stall.
- Handshake:
  - Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && s2 advances.
  - in_ready = !s1_valid || s2 advances (combinational from out_ready, no other path).
- Throughput: one op per cycle sustained while out_ready=1.
- Stall behaviour:
  - With out_ready=0 the pipeline holds up to 2 ops, then in_ready=0.
  - Held outputs stay bit-stable while out_valid && !out_ready.
- Simultaneous events: in the same cycle as an out transfer, s1 moves into s2 and a new input enters s1. No bubble is inserted.
- Source rules: inputs are sampled only on an in transfer; in_a/in_b/in_op may change freely otherwise.
- Reset mid-operation: all in-flight ops are discarded, with no out_valid afterwards for them. Reset wins over any simultaneous transfer.
- Boundary cases:
  - Shift amount XLEN-1 is legal; upper B bits are ignored (B=33 with XLEN=32 shifts by 1).
  - SLT on 0x80000000 vs 0 gives 1, while SLTU gives 0.

Decomposition:
- Package alu_pkg holds:
  - the op-code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_SRL, OP_SLL, OP_SRA, OP_SLT, OP_SLTU);
  - a function is_legal_op.
- Sub-module alu_core: purely combinational XLEN-parametrised datapath (result + 4 flags + illegal) instantiated between s1 and s2. alu_pipe owns only registers and handshake.

Test Plan:
- ADD 0x7FFFFFFF+1, tag 3, out_ready=1 -> cycle N+2: result 0x80000000, ovf=1, neg=1, carry=0, zero=0, tag 3.
- SUB 5-5 then SUB 0-1 back-to-back -> consecutive cycles: result 0, zero=1, carry=1; then 0xFFFFFFFF, carry=0, neg=1.
- Shifts:
  - SRA 0xF0000000 by B=0x24 -> 0xFF000000.
  - SRL same -> 0x0F000000.
  - SLL 1 by 31 -> 0x80000000.
- Backpressure: issue 4 ops with out_ready=0 -> in_ready drops after 2 accepts, outputs stable. Then raise out_ready -> all 4 results emerge in order, one per cycle, no loss or duplication.
- Illegal op 1111 -> result 0, out_illegal=1. SLT 0x80000000,0 -> 1; SLTU -> 0.
- Assert rst while 2 ops are in flight -> next cycle out_valid=0, in_ready=1; no stale result ever appears.
